// File: rtl/mem_seq.sv
// mem_seq: sequences core data reads/writes and 32-bit instruction fetches onto a 16-bit word memory port
// Ports: clk/rst (sync, active-low); core side c_addr/c_wdata/c_rd/c_wr/c_instr/c_rd_done in,
// c_rdata/c_instr_out/c_busy/c_ready/c_cack out; memory side m_addr/m_wdata/m_req/m_we out,
// m_ack/m_rvalid/m_rdata in. Define MEM_SEQ_ILAST_EN to reuse the last fetched instruction.
module mem_seq #(
  parameter int MEM_AW = 17,
  parameter bit IHI_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       c_addr,
  input  logic [15:0]       c_wdata,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic              c_instr,
  input  logic              c_rd_done,
  output logic [15:0]       c_rdata,
  output logic [31:0]       c_instr_out,
  output logic              c_busy,
  output logic              c_ready,
  output logic              c_cack,
  output logic [MEM_AW-1:0] m_addr,
  output logic [15:0]       m_wdata,
  output logic              m_req,
  output logic              m_we,
  input  logic              m_ack,
  input  logic              m_rvalid,
  input  logic [15:0]       m_rdata
);
  typedef enum logic [3:0] {IDLE, DREQ, DWAIT, ILO_REQ, ILO_WAIT, IHI_REQ, IHI_WAIT, RDONE, WDONE} state_t;
  localparam state_t FIRST_I = IHI_FIRST ? IHI_REQ : ILO_REQ;
  localparam state_t LO_NEXT = IHI_FIRST ? RDONE : IHI_REQ;
  localparam state_t HI_NEXT = IHI_FIRST ? ILO_REQ : RDONE;
  state_t state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] instr_q, instr_d;
  logic wr_q, wr_d, busy_q, busy_d, ready_q, ready_d, cack_q, cack_d, req_q, req_d, we_q, we_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic d_cap, lo_cap, hi_cap, hit;
`ifdef MEM_SEQ_ILAST_EN
  logic [15:0] tag_q, tag_d;
  logic tag_v_q, tag_v_d;
  assign hit = tag_v_q && tag_q == c_addr;
`else
  assign hit = 1'b0;
`endif
  function automatic logic [MEM_AW-1:0] maddr(input logic sp, input logic [15:0] w);
    logic [MEM_AW-1:0] r;
    r = '0;
    r[15:0] = w;
    r[MEM_AW-1] = sp;
    return r;
  endfunction
  // read data may arrive together with m_ack, letting the WAIT state be skipped
  assign d_cap = m_rvalid && (state_q == DWAIT || (state_q == DREQ && m_ack && !wr_q));
  assign lo_cap = m_rvalid && (state_q == ILO_WAIT || (state_q == ILO_REQ && m_ack));
  assign hi_cap = m_rvalid && (state_q == IHI_WAIT || (state_q == IHI_REQ && m_ack));
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    cack_d = 1'b0;
    case (state_q)
      IDLE: if (c_wr || c_rd) begin
        addr_d = c_addr;
        wdata_d = c_wdata;
        wr_d = c_wr;
        cack_d = 1'b1;
        state_d = (c_wr || !c_instr) ? DREQ : hit ? RDONE : FIRST_I;
      end
      DREQ: if (m_ack) state_d = wr_q ? WDONE : m_rvalid ? RDONE : DWAIT;
      DWAIT: if (m_rvalid) state_d = RDONE;
      ILO_REQ: if (m_ack) state_d = m_rvalid ? LO_NEXT : ILO_WAIT;
      ILO_WAIT: if (m_rvalid) state_d = LO_NEXT;
      IHI_REQ: if (m_ack) state_d = m_rvalid ? HI_NEXT : IHI_WAIT;
      IHI_WAIT: if (m_rvalid) state_d = HI_NEXT;
      RDONE: if (c_rd_done || !c_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = d_cap ? m_rdata : rdata_q;
    instr_d = {hi_cap ? m_rdata : instr_q[31:16], lo_cap ? m_rdata : instr_q[15:0]};
`ifdef MEM_SEQ_ILAST_EN
    tag_d = tag_q;
    tag_v_d = tag_v_q;
    // a write to either half of the remembered instruction invalidates it
    if (state_q == IDLE && c_wr && c_addr[15:1] == tag_q[14:0]) tag_v_d = 1'b0;
    if ((lo_cap && LO_NEXT == RDONE) || (hi_cap && HI_NEXT == RDONE)) begin
      tag_d = addr_q;
      tag_v_d = 1'b1;
    end
`endif
    busy_d = state_d != IDLE;
    ready_d = state_d == RDONE || state_d == WDONE;
    req_d = state_d == DREQ || state_d == ILO_REQ || state_d == IHI_REQ;
    we_d = state_d == DREQ && wr_d;
    // instruction index is doubled into a word address; the shift wraps within 16 bits
    maddr_d = state_d == DREQ ? maddr(1'b0, addr_d) :
              state_d == ILO_REQ ? maddr(1'b1, {addr_d[14:0], 1'b0}) :
              state_d == IHI_REQ ? maddr(1'b1, {addr_d[14:0], 1'b1}) : maddr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      instr_q <= '0;
      wr_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
      cack_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      maddr_q <= '0;
`ifdef MEM_SEQ_ILAST_EN
      tag_q <= '0;
      tag_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      instr_q <= instr_d;
      wr_q <= wr_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      cack_q <= cack_d;
      req_q <= req_d;
      we_q <= we_d;
      maddr_q <= maddr_d;
`ifdef MEM_SEQ_ILAST_EN
      tag_q <= tag_d;
      tag_v_q <= tag_v_d;
`endif
    end
  end
  assign c_rdata = rdata_q;
  assign c_instr_out = instr_q;
  assign c_busy = busy_q;
  assign c_ready = ready_q;
  assign c_cack = cack_q;
  assign m_addr = maddr_q;
  assign m_wdata = wdata_q;
  assign m_req = req_q;
  assign m_we = we_q;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: self-checking bench for mem_seq with a delay-programmable memory responder
module tb_mem_seq;
  localparam int AW = 17;
  localparam bit IHI_FIRST = 1'b0;
`ifdef MEM_SEQ_ILAST_EN
  localparam bit ILAST = 1'b1;
`else
  localparam bit ILAST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] c_addr = '0, c_wdata = '0, c_rdata, m_wdata, m_rdata = '0;
  logic c_rd = 1'b0, c_wr = 1'b0, c_instr = 1'b0, c_rd_done = 1'b0;
  logic [31:0] c_instr_out;
  logic c_busy, c_ready, c_cack, m_req, m_we;
  logic m_ack = 1'b0, m_rvalid = 1'b0;
  logic [AW-1:0] m_addr;
  mem_seq #(.MEM_AW(AW), .IHI_FIRST(IHI_FIRST)) dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_wdata(c_wdata), .c_rd(c_rd), .c_wr(c_wr),
    .c_instr(c_instr), .c_rd_done(c_rd_done), .c_rdata(c_rdata), .c_instr_out(c_instr_out),
    .c_busy(c_busy), .c_ready(c_ready), .c_cack(c_cack), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_req(m_req), .m_we(m_we), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [15:0] mem [0:131071];
  logic [15:0] ref_mem [0:131071];
  logic [33:0] log_q [$];
  int ack_dly = 0, rv_dly = 0, reqc_cnt = 0;
  bit mv = 1'b0;
  logic [15:0] mtag = '0;
  logic [31:0] last_io = '0;

  typedef struct {
    bit wr; bit ins; logic [15:0] a; logic [15:0] wd;
    int ad; int rv; int lat; int reqc; logic [31:0] ev;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [16:0] iaddr(input logic [15:0] idx, input bit hi);
    logic [15:0] w;
    w = 16'(32'(idx) * 2 + 32'(hi));
    return {1'b1, w};
  endfunction

  // memory: request sampled at a negedge, ack after ack_dly cycles, read data rv_dly cycles after ack
  task automatic serve();
    logic [16:0] a;
    logic we;
    logic [15:0] wd;
    int ad, rv;
    a = m_addr; we = m_we; wd = m_wdata; ad = ack_dly; rv = rv_dly;
    repeat (ad) @(negedge clk);
    m_ack = 1'b1;
    log_q.push_back({we, a, wd});
    if (we) mem[a] = wd;
    else if (rv == 0) begin m_rvalid = 1'b1; m_rdata = mem[a]; end
    @(negedge clk);
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    if (!we && rv > 0) begin
      repeat (rv - 1) @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata = mem[a];
      @(negedge clk);
      m_rvalid = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (m_req === 1'b1) serve();
      else @(negedge clk);
    end
  end

  always @(negedge clk) if (m_req === 1'b1) reqc_cnt++;

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (c_ready === 1'b1) begin n = i; break; end
    end
    if (n == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: c_ready never rose within 300 cycles");
    end
  endtask

  task automatic run(input bit wr, input bit ins, input logic [15:0] a, input logic [15:0] wd,
                     output int lat, output int reqc, output logic [15:0] rd, output logic [31:0] io);
    int n, base;
    log_q.delete();
    @(negedge clk);
    base = reqc_cnt;
    c_addr = a; c_wdata = wd; c_instr = ins; c_wr = wr; c_rd = !wr;
    @(negedge clk);
    chk("cack", c_cack, 1);
    chk("busy_after_accept", c_busy, 1);
    n = 0;
    if (c_ready !== 1'b1) wait_ready(n);
    lat = (c_ready === 1'b1) ? n + 1 : 0;
    reqc = reqc_cnt - base;
    rd = c_rdata;
    io = c_instr_out;
    c_rd = 1'b0; c_wr = 1'b0; c_instr = 1'b0;
    @(negedge clk);
    chk("idle_busy", c_busy, 0);
    chk("idle_ready", c_ready, 0);
  endtask

  // reference: latency and memory traffic follow from the delays; data from a shadow memory
  task automatic mtxn(input bit wr, input bit ins, input logic [15:0] a, input logic [15:0] wd,
                      output int lat, output int reqc, output logic [15:0] rd, output logic [31:0] io);
    int elat, ereq;
    logic [33:0] elog [$];
    logic [15:0] erd;
    logic [31:0] eio;
    bit hit;
    hit = ILAST && !wr && ins && mv && mtag == a;
    erd = '0; eio = last_io;
    if (wr) begin
      elat = ack_dly + 2; ereq = ack_dly + 1;
      elog.push_back({1'b1, 1'b0, a, wd});
      ref_mem[{1'b0, a}] = wd;
      if (a == 16'(32'(mtag) * 2) || a == 16'(32'(mtag) * 2 + 1)) mv = 1'b0;
    end else if (!ins) begin
      elat = ack_dly + rv_dly + 2; ereq = ack_dly + 1;
      elog.push_back({1'b0, 1'b0, a, wd});
      erd = ref_mem[{1'b0, a}];
    end else if (hit) begin
      elat = 1; ereq = 0;
    end else begin
      elat = 2 * (ack_dly + rv_dly + 1) + 1; ereq = 2 * (ack_dly + 1);
      if (IHI_FIRST) begin
        elog.push_back({1'b0, iaddr(a, 1), wd});
        elog.push_back({1'b0, iaddr(a, 0), wd});
      end else begin
        elog.push_back({1'b0, iaddr(a, 0), wd});
        elog.push_back({1'b0, iaddr(a, 1), wd});
      end
      eio = {ref_mem[iaddr(a, 1)], ref_mem[iaddr(a, 0)]};
      last_io = eio; mv = 1'b1; mtag = a;
    end
    run(wr, ins, a, wd, lat, reqc, rd, io);
    chk("latency", lat, elat);
    chk("req_cycles", reqc, ereq);
    chk("mem_accesses", log_q.size(), elog.size());
    for (int i = 0; i < elog.size() && i < log_q.size(); i++) chk("mem_access", log_q[i], elog[i]);
    if (!wr && !ins) chk("rdata", rd, erd);
    if (!wr && ins) chk("instr", io, eio);
  endtask

  initial begin
    int lat, reqc, n;
    logic [15:0] rd, a;
    logic [31:0] io;
    int kind;
    for (int i = 0; i < 131072; i++) begin
      mem[i] = 16'(i * 40503 + 31 + (i >> 16) * 12345);
      ref_mem[i] = mem[i];
    end
    mem[17'h00012] = 16'hBEEF; mem[17'h1000A] = 16'h1234; mem[17'h1000B] = 16'hABCD;
    mem[17'h1000C] = 16'h0C0C; mem[17'h1000D] = 16'hD0D0;
    mem[17'h10002] = 16'h2222; mem[17'h10003] = 16'h3333;
    for (int i = 0; i < 131072; i++) ref_mem[i] = mem[i];
    tbl = '{
      '{1'b0, 1'b0, 16'h0012, 16'h0000, 0, 0, 2, 1, 32'h0000BEEF},
      '{1'b0, 1'b1, 16'h0005, 16'h0000, 0, 0, 3, 2, 32'hABCD1234},
      '{1'b1, 1'b0, 16'h0100, 16'h5A5A, 4, 0, 6, 5, 32'h0},
      '{1'b0, 1'b0, 16'h0100, 16'h0000, 0, 0, 2, 1, 32'h00005A5A},
      '{1'b0, 1'b0, 16'h0012, 16'h0000, 2, 3, 7, 3, 32'h0000BEEF},
      '{1'b0, 1'b1, 16'h0006, 16'h0000, 1, 1, 7, 4, 32'hD0D00C0C},
      '{1'b1, 1'b0, 16'hFFFF, 16'h1357, 0, 0, 2, 1, 32'h0},
      '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 2, 1, 32'h00001357},
      '{1'b0, 1'b1, 16'h8001, 16'h0000, 0, 0, 3, 2, 32'h33332222}
    };

    repeat (3) @(negedge clk);
    chk("rst_m_req", m_req, 0); chk("rst_m_we", m_we, 0); chk("rst_busy", c_busy, 0);
    chk("rst_ready", c_ready, 0); chk("rst_cack", c_cack, 0); chk("rst_rdata", c_rdata, 0);
    chk("rst_instr", c_instr_out, 0); chk("rst_m_addr", m_addr, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      ack_dly = tbl[i].ad; rv_dly = tbl[i].rv;
      mtxn(tbl[i].wr, tbl[i].ins, tbl[i].a, tbl[i].wd, lat, reqc, rd, io);
      chk("tbl_latency", lat, tbl[i].lat);
      chk("tbl_req_cycles", reqc, tbl[i].reqc);
      if (!tbl[i].wr && !tbl[i].ins) chk("tbl_rdata", rd, tbl[i].ev[15:0]);
      if (!tbl[i].wr && tbl[i].ins) chk("tbl_instr", io, tbl[i].ev);
    end

    // result held while the core keeps c_rd high; c_rd_done alone releases it
    ack_dly = 0; rv_dly = 0;
    @(negedge clk);
    c_addr = 16'h0012; c_instr = 1'b0; c_rd = 1'b1;
    wait_ready(n);
    chk("hold_latency", n, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready", c_ready, 1); chk("hold_rdata", c_rdata, 16'hBEEF); chk("hold_busy", c_busy, 1);
    end
    c_rd_done = 1'b1;
    @(negedge clk);
    chk("rd_done_ready", c_ready, 0); chk("rd_done_busy", c_busy, 0);
    c_rd_done = 1'b0; c_rd = 1'b0;
    @(negedge clk);
    chk("rd_done_no_reaccept", c_busy, 0);

    // simultaneous read and write: write wins, the held read follows
    log_q.delete();
    c_addr = 16'h0001; c_wdata = 16'h2468; c_wr = 1'b1; c_rd = 1'b1;
    wait_ready(n);
    chk("both_wr_latency", n, 2);
    chk("both_wr_first", log_q.size() > 0 ? log_q[0] : 34'h0, {1'b1, 17'h00001, 16'h2468});
    c_wr = 1'b0;
    wait_ready(n);
    chk("both_rd_latency", n, 3);
    chk("both_rd_rdata", c_rdata, 16'h2468);
    chk("both_accesses", log_q.size(), 2);
    chk("both_rd_second", log_q.size() > 1 ? log_q[1] : 34'h0, {1'b0, 17'h00001, 16'h2468});
    ref_mem[17'h00001] = 16'h2468;
    c_rd = 1'b0;
    @(negedge clk);
    chk("both_idle", c_busy, 0);

    // reset while waiting for the low instruction half
    ack_dly = 0; rv_dly = 3;
    @(negedge clk);
    c_addr = 16'h0005; c_instr = 1'b1; c_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", c_busy, 1);
    rst = 1'b0; c_rd = 1'b0; c_instr = 1'b0;
    @(negedge clk);
    chk("midrst_m_req", m_req, 0); chk("midrst_busy", c_busy, 0);
    chk("midrst_ready", c_ready, 0); chk("midrst_instr", c_instr_out, 0);
    rst = 1'b1; mv = 1'b0; last_io = '0;
    repeat (6) @(negedge clk);
    ack_dly = 0; rv_dly = 0;
    mtxn(1'b0, 1'b1, 16'h0005, 16'h0000, lat, reqc, rd, io);
    chk("post_rst_instr", io, 32'hABCD1234);
    chk("post_rst_latency", lat, 3);

    // repeated fetch, then a write to the fetched instruction's high word
    mtxn(1'b0, 1'b1, 16'h0005, 16'h0000, lat, reqc, rd, io);
    chk("refetch_instr", io, 32'hABCD1234);
    chk("refetch_latency", lat, ILAST ? 1 : 3);
    mtxn(1'b1, 1'b0, 16'h000B, 16'hABCD, lat, reqc, rd, io);
    mtxn(1'b0, 1'b1, 16'h0005, 16'h0000, lat, reqc, rd, io);
    chk("after_wr_latency", lat, 3);
    chk("after_wr_reqs", reqc, 2);

    for (int k = 0; k < 120; k++) begin
      kind = int'($urandom_range(0, 2));
      ack_dly = int'($urandom_range(0, 3));
      rv_dly = int'($urandom_range(0, 3));
      a = kind == 2 ? 16'($urandom_range(0, 7)) :
          $urandom_range(0, 1) == 1 ? 16'($urandom_range(0, 17)) : 16'($urandom);
      mtxn(kind == 1, kind == 2, a, 16'($urandom), lat, reqc, rd, io);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
